id_stage_regfile: RTL and testbench

- Instruction-decode stage that sits directly upstream of the ID/EX pipeline register and drives every ID_* input of that register.
- Holds the 32 x 64-bit architectural register file: two combinational read ports, one write-back port with write-through bypass.
- Detects load-use hazards against the instruction currently in EX. On a hazard it stalls PC and IF/ID and injects a bubble (zeroed control bundles) into ID/EX.

---
 rtl/id_stage_regfile.sv | 62 ++++++
 tb/tb_id_stage_regfile.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/id_stage_regfile.sv
// id_stage_regfile: decode stage with 32x64 register file, write-through bypass and load-use bubble injection.
// Optional stall counter (stall_cnt, stall_cnt_clr) is built when ID_STALL_CNT_EN is defined.
module id_stage_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG_LOG2 = 5,
  parameter int IMM_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef ID_STALL_CNT_EN
  input  logic                 stall_cnt_clr,
  output logic [31:0]          stall_cnt,
`endif
  input  logic [NREG_LOG2-1:0] IF_rs1,
  input  logic [NREG_LOG2-1:0] IF_rs2,
  input  logic [NREG_LOG2-1:0] IF_rd,
  input  logic [5:0]           IF_EX_CTRL,
  input  logic [3:0]           IF_MEM_CTRL,
  input  logic [2:0]           IF_WB_CTRL,
  input  logic [IMM_W-1:0]     IF_IMM,
  input  logic [NREG_LOG2-1:0] EX_WReg1,
  input  logic [3:0]           EX_MEM_CTRL,
  input  logic                 WB_we,
  input  logic [NREG_LOG2-1:0] WB_addr,
  input  logic [DATA_W-1:0]    WB_data,
  output logic [DATA_W-1:0]    ID_R1out,
  output logic [DATA_W-1:0]    ID_R2out,
  output logic [NREG_LOG2-1:0] ID_WReg1,
  output logic [NREG_LOG2-1:0] ID_rs2,
  output logic [5:0]           ID_EX_CTRL,
  output logic [3:0]           ID_MEM_CTRL,
  output logic [2:0]           ID_WB_CTRL,
  output logic [IMM_W-1:0]     ID_IMM,
  output logic                 stall
);
  logic [DATA_W-1:0] regs [2**NREG_LOG2];
  logic haz;
  logic unused_ex_mem;
  assign unused_ex_mem = ^{EX_MEM_CTRL[3:2], EX_MEM_CTRL[0]};
  // regs[0] is never written, so it stays at its reset value of 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 2**NREG_LOG2; i++) regs[i] <= '0;
    else if (WB_we && WB_addr != '0) regs[WB_addr] <= WB_data;
  always_comb begin
    haz = reset && EX_MEM_CTRL[1] && EX_WReg1 != '0 && (EX_WReg1 == IF_rs1 || EX_WReg1 == IF_rs2);
    ID_R1out = !reset ? '0 : (WB_we && WB_addr == IF_rs1 && IF_rs1 != '0) ? WB_data : regs[IF_rs1];
    ID_R2out = !reset ? '0 : (WB_we && WB_addr == IF_rs2 && IF_rs2 != '0) ? WB_data : regs[IF_rs2];
    ID_WReg1 = IF_rd;
    ID_rs2 = IF_rs2;
    ID_IMM = IF_IMM;
    ID_EX_CTRL = haz ? '0 : IF_EX_CTRL;
    ID_MEM_CTRL = haz ? '0 : IF_MEM_CTRL;
    ID_WB_CTRL = haz ? '0 : IF_WB_CTRL;
    stall = haz;
  end
`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cnt <= '0;
    else if (stall_cnt_clr) stall_cnt <= '0;
    else if (haz && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_id_stage_regfile.sv
// tb_id_stage_regfile: directed plus randomized checks of id_stage_regfile against an array-based reference model.
module tb_id_stage_regfile;
  logic clk = 0, reset = 0;
  logic [4:0] IF_rs1 = 0, IF_rs2 = 0, IF_rd = 0, EX_WReg1 = 0, WB_addr = 0;
  logic [5:0] IF_EX_CTRL = 0;
  logic [3:0] IF_MEM_CTRL = 0, EX_MEM_CTRL = 0;
  logic [2:0] IF_WB_CTRL = 0;
  logic [11:0] IF_IMM = 0;
  logic WB_we = 0;
  logic [63:0] WB_data = 0;
  logic [63:0] ID_R1out, ID_R2out;
  logic [4:0] ID_WReg1, ID_rs2;
  logic [5:0] ID_EX_CTRL;
  logic [3:0] ID_MEM_CTRL;
  logic [2:0] ID_WB_CTRL;
  logic [11:0] ID_IMM;
  logic stall;
  int checks = 0, errors = 0;
  logic [63:0] ref_regs [32];
  logic [31:0] ref_cnt = 0;
`ifdef ID_STALL_CNT_EN
  logic stall_cnt_clr = 0;
  logic [31:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  id_stage_regfile dut (
    .clk(clk), .reset(reset),
`ifdef ID_STALL_CNT_EN
    .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt),
`endif
    .IF_rs1(IF_rs1), .IF_rs2(IF_rs2), .IF_rd(IF_rd), .IF_EX_CTRL(IF_EX_CTRL),
    .IF_MEM_CTRL(IF_MEM_CTRL), .IF_WB_CTRL(IF_WB_CTRL), .IF_IMM(IF_IMM),
    .EX_WReg1(EX_WReg1), .EX_MEM_CTRL(EX_MEM_CTRL), .WB_we(WB_we), .WB_addr(WB_addr),
    .WB_data(WB_data), .ID_R1out(ID_R1out), .ID_R2out(ID_R2out), .ID_WReg1(ID_WReg1),
    .ID_rs2(ID_rs2), .ID_EX_CTRL(ID_EX_CTRL), .ID_MEM_CTRL(ID_MEM_CTRL),
    .ID_WB_CTRL(ID_WB_CTRL), .ID_IMM(ID_IMM), .stall(stall)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (!reset) return 64'd0;
    if (WB_we && WB_addr == a && a != 0) return WB_data;
    return a == 0 ? 64'd0 : ref_regs[a];
  endfunction
  function automatic logic exp_haz();
    return reset && EX_MEM_CTRL[1] && EX_WReg1 != 0 && (EX_WReg1 == IF_rs1 || EX_WReg1 == IF_rs2);
  endfunction
  task automatic check_all(input string tag);
    logic h;
    h = exp_haz();
    check({tag, ".r1"}, ID_R1out, exp_rd(IF_rs1));
    check({tag, ".r2"}, ID_R2out, exp_rd(IF_rs2));
    check({tag, ".stall"}, 64'(stall), 64'(h));
    check({tag, ".ex"}, 64'(ID_EX_CTRL), h ? 64'd0 : 64'(IF_EX_CTRL));
    check({tag, ".mem"}, 64'(ID_MEM_CTRL), h ? 64'd0 : 64'(IF_MEM_CTRL));
    check({tag, ".wb"}, 64'(ID_WB_CTRL), h ? 64'd0 : 64'(IF_WB_CTRL));
    check({tag, ".pass"}, {ID_WReg1, ID_rs2, ID_IMM}, {IF_rd, IF_rs2, IF_IMM});
`ifdef ID_STALL_CNT_EN
    check({tag, ".cnt"}, 64'(stall_cnt), 64'(ref_cnt));
`endif
  endtask
  task automatic tick();
    logic h;
    h = exp_haz();
    @(posedge clk);
    if (reset && WB_we && WB_addr != 0) ref_regs[WB_addr] = WB_data;
`ifdef ID_STALL_CNT_EN
    if (reset) ref_cnt = stall_cnt_clr ? 32'd0 : (h && ref_cnt != 32'hFFFFFFFF) ? ref_cnt + 1 : ref_cnt;
`endif
    @(negedge clk);
  endtask
  task automatic cyc(input string tag);
    #1 check_all(tag);
    tick();
  endtask
  task automatic do_reset();
    reset = 0;
    foreach (ref_regs[i]) ref_regs[i] = 0;
    ref_cnt = 0;
    #1 check_all("rst_low");
    reset = 1;
  endtask
  function automatic logic [4:0] rnd_idx();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction
  initial begin
    foreach (ref_regs[i]) ref_regs[i] = 0;
    IF_rs1 = 5; IF_rs2 = 31; EX_MEM_CTRL = 4'b0010; EX_WReg1 = 5; IF_EX_CTRL = 6'h11;
    #12 check_all("rst");
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1; EX_MEM_CTRL = 0;
    #1 check("post_rst_r1", ID_R1out, 64'd0);
    check("post_rst_r2", ID_R2out, 64'd0);
    WB_we = 1; WB_addr = 3; WB_data = 64'hDEAD_BEEF_0000_0001;
    cyc("wr3");
    WB_we = 0; IF_rs1 = 3;
    #1 check("rd3", ID_R1out, 64'hDEAD_BEEF_0000_0001);
    cyc("rd3");
    WB_we = 1; WB_addr = 7; WB_data = 64'h55; IF_rs2 = 7;
    #1 check("bypass", ID_R2out, 64'h55);
    cyc("bypass");
    WB_addr = 0; WB_data = 64'hFF; IF_rs1 = 0; IF_rs2 = 0;
    cyc("wr0");
    WB_we = 0;
    #1 check("r0", ID_R1out, 64'd0);
    WB_we = 0; EX_MEM_CTRL = 4'b0010; EX_WReg1 = 4; IF_rs1 = 4; IF_EX_CTRL = 6'h2A;
    IF_MEM_CTRL = 4'h3; IF_WB_CTRL = 3'h1;
    #1 check("lu_stall", 64'(stall), 64'd1);
    check("lu_ctrl", {ID_EX_CTRL, ID_MEM_CTRL, ID_WB_CTRL}, 64'd0);
    cyc("lu");
    EX_MEM_CTRL = 0;
    #1 check("lu_release", 64'(stall), 64'd0);
    check("lu_ex", 64'(ID_EX_CTRL), 64'h2A);
    cyc("lu2");
    EX_MEM_CTRL = 4'b0010; EX_WReg1 = 0; IF_rs1 = 0;
    #1 check("nofs_r0", 64'(stall), 64'd0);
    cyc("nofs_r0");
    EX_MEM_CTRL = 4'b0001; EX_WReg1 = 4; IF_rs2 = 4;
    #1 check("nofs_st", 64'(stall), 64'd0);
    cyc("nofs_st");
`ifdef ID_STALL_CNT_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      EX_MEM_CTRL = 4'b0010; EX_WReg1 = 9; IF_rs1 = 9;
      cyc("cnt_haz");
      EX_MEM_CTRL = 0;
      cyc("cnt_idle");
    end
    check("cnt3", 64'(stall_cnt), 64'd3);
    EX_MEM_CTRL = 4'b0010; stall_cnt_clr = 1;
    cyc("cnt_clr");
    stall_cnt_clr = 0;
    check("cnt_clr0", 64'(stall_cnt), 64'd0);
    cyc("cnt_a");
    cyc("cnt_b");
    check("cnt2", 64'(stall_cnt), 64'd2);
    do_reset();
    check("cnt_rst", 64'(stall_cnt), 64'd0);
    EX_MEM_CTRL = 0;
`endif
    for (int n = 0; n < 800; n++) begin
      IF_rs1 = rnd_idx(); IF_rs2 = rnd_idx(); IF_rd = 5'($urandom);
      IF_EX_CTRL = 6'($urandom); IF_MEM_CTRL = 4'($urandom); IF_WB_CTRL = 3'($urandom);
      IF_IMM = 12'($urandom); EX_WReg1 = rnd_idx(); EX_MEM_CTRL = 4'($urandom);
      WB_we = 1'($urandom); WB_addr = rnd_idx(); WB_data = {32'($urandom), 32'($urandom)};
`ifdef ID_STALL_CNT_EN
      stall_cnt_clr = ($urandom_range(0, 19) == 0);
`endif
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
